// File: rtl/handshake_pkg.sv
// Shared helpers for valid/ready arbiters in the dataflow fabric.
// Request bundles are NUM_REQ-wide vectors, bit i = channel i.
package handshake_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin first-one search starting at ptr_i, wrapping mod N.
// Reusable by any shared-unit arbiter.
module rr_priority_pick
  import handshake_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/handshake_const_arbiter.sv
// Round-robin shared constant source with a one-entry output
// register; pass-through load keeps full throughput.
module handshake_const_arbiter
  import handshake_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONST_TABLE =
    128'hFFFFFFFF_000260E6_00000001_00000000,
  localparam int IDX_W = clog2_min1(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_W-1:0]      outs_index,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               load_en;
  logic               grant;

  rr_priority_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req_i (ctrl_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign load_en = !valid_q || outs_ready;
  // Gate on rst so no token is accepted while reset is held.
  assign grant   = load_en && pick_any && rst;

  assign ctrl_ready = grant ? pick_gnt : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (grant) begin
      valid_d = 1'b1;
      data_d  = CONST_TABLE[pick_idx*DATA_WIDTH +: DATA_WIDTH];
      idx_d   = pick_idx;
      ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                  : pick_idx + 1'b1;
    end else if (outs_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign outs       = data_q;
  assign outs_index = idx_q;
  assign outs_valid = valid_q;

endmodule

// File: tb/tb_handshake_const_arbiter.sv
// Bench for handshake_const_arbiter: directed vectors plus a
// behavioural reference checked every cycle.
module tb_handshake_const_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  ctrl_valid;
  logic [3:0]  ctrl_ready;
  logic [31:0] outs;
  logic [1:0]  outs_index;
  logic        outs_valid;
  logic        outs_ready;

  int vecs;
  int miscompares;

  handshake_const_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs       (outs),
    .outs_index (outs_index),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  logic [31:0] ctab [4];
  initial begin
    ctab[0] = 32'h0000_0000;
    ctab[1] = 32'h0000_0001;
    ctab[2] = 32'h0002_60E6;
    ctab[3] = 32'hFFFF_FFFF;
  end

  // Reference: token register contents and next-to-serve index.
  bit          m_valid;
  logic [31:0] m_data;
  int          m_idx;
  int          m_ptr;

  function automatic logic [3:0] exp_ready();
    int j;
    if (rst !== 1'b1) return 4'b0;
    if (m_valid && !outs_ready) return 4'b0;
    for (int k = 0; k < 4; k++) begin
      j = (m_ptr + k) % 4;
      if (ctrl_valid[j]) return 4'(1 << j);
    end
    return 4'b0;
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [3:0] r;
    if (!rst) begin
      m_valid = 0;
      m_data  = 0;
      m_idx   = 0;
      m_ptr   = 0;
    end else begin
      r = exp_ready();
      if (r != 0) begin
        for (int g = 0; g < 4; g++)
          if (r[g]) begin
            m_valid = 1;
            m_data  = ctab[g];
            m_idx   = g;
            m_ptr   = (g + 1) % 4;
          end
      end else if (outs_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  bit cmp_en;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_ready", 64'(ctrl_ready), 64'(exp_ready()));
      check("m_valid", 64'(outs_valid), 64'(m_valid));
      check("m_outs", 64'(outs), 64'(m_data));
      check("m_index", 64'(outs_index), 64'(m_idx));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    repeat (3) next_cycle();
    rst = 1;
  endtask

  logic [31:0] seq_v [5];
  int          seq_i [5];

  initial begin
    vecs = 0;
    miscompares = 0;
    cmp_en = 0;
    rst = 0;
    ctrl_valid = 4'b1111;
    outs_ready = 0;
    #1;
    cmp_en = 1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_ready", 64'(ctrl_ready), 64'h0);
    check("rst_valid", 64'(outs_valid), 64'h0);
    check("rst_outs", 64'(outs), 64'h0);
    next_cycle();

    // 1: single request after reset
    rst = 1;
    ctrl_valid = 4'b0100;
    outs_ready = 1;
    @(negedge clk);
    check("t1_ready", 64'(ctrl_ready), 64'h4);
    next_cycle();
    ctrl_valid = 4'b0000;
    @(negedge clk);
    check("t1_outs", 64'(outs), 64'h260E6);
    check("t1_index", 64'(outs_index), 64'd2);
    check("t1_valid", 64'(outs_valid), 64'd1);
    // 5: drain with no request
    next_cycle();
    @(negedge clk);
    check("t5_valid", 64'(outs_valid), 64'd0);
    check("t5_outs", 64'(outs), 64'h260E6);
    check("t5_index", 64'(outs_index), 64'd2);
    // 4: pointer at 3 wraps to requester 0
    next_cycle();
    ctrl_valid = 4'b0001;
    @(negedge clk);
    check("t4_ready", 64'(ctrl_ready), 64'h1);
    next_cycle();
    ctrl_valid = 4'b0011;
    @(negedge clk);
    check("t4_outs", 64'(outs), 64'h0);
    check("t4_ptr1", 64'(ctrl_ready), 64'h2);
    next_cycle();
    ctrl_valid = 4'b0000;
    next_cycle();

    // 2: all valid, grants rotate with no bubble
    do_reset();
    ctrl_valid = 4'b1111;
    outs_ready = 1;
    seq_i = '{0, 1, 2, 3, 0};
    seq_v = '{32'h0, 32'h1, 32'h260E6, 32'hFFFFFFFF, 32'h0};
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_valid", 64'(outs_valid), 64'd1);
      check("t2_index", 64'(outs_index), 64'(seq_i[i]));
      check("t2_outs", 64'(outs), 64'(seq_v[i]));
      next_cycle();
    end
    ctrl_valid = 4'b0000;
    next_cycle();

    // 3: back-pressure holds everything
    do_reset();
    ctrl_valid = 4'b0011;
    outs_ready = 1;
    next_cycle();
    outs_ready = 0;
    ctrl_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_ready", 64'(ctrl_ready), 64'h0);
      check("t3_outs", 64'(outs), 64'h0);
      check("t3_index", 64'(outs_index), 64'd0);
      check("t3_valid", 64'(outs_valid), 64'd1);
      next_cycle();
    end
    outs_ready = 1;
    @(negedge clk);
    check("t3_release", 64'(ctrl_ready), 64'h2);
    next_cycle();
    ctrl_valid = 4'b0000;
    outs_ready = 0;
    @(negedge clk);
    check("t3_outs1", 64'(outs), 64'h1);
    check("t3_index1", 64'(outs_index), 64'd1);

    // 6: async reset while a token is pending
    next_cycle();
    ctrl_valid = 4'b1010;
    #2;
    rst = 0;
    #1;
    check("t6_valid", 64'(outs_valid), 64'd0);
    check("t6_outs", 64'(outs), 64'h0);
    check("t6_ready", 64'(ctrl_ready), 64'h0);
    next_cycle();
    next_cycle();
    rst = 1;
    outs_ready = 1;
    @(negedge clk);
    check("t6_first", 64'(ctrl_ready), 64'h2);
    next_cycle();
    ctrl_valid = 4'b0000;
    @(negedge clk);
    check("t6_index", 64'(outs_index), 64'd1);

    // mixed traffic, checked only against the reference
    for (int i = 0; i < 200; i++) begin
      next_cycle();
      ctrl_valid = 4'($urandom_range(0, 15));
      outs_ready = 1'($urandom_range(0, 1));
    end
    next_cycle();
    cmp_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miscompares);
    $finish;
  end

endmodule
